// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;
    localparam int CNT_W      = 4;
    localparam int DATA_W     = 32;
    localparam int BYTE_OFS_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, synchronous write, combinational read
module dmem_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with programmable wait states
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);
    localparam int IDX_W  = idx_w(DEPTH);
    localparam int IDX_HI = IDX_W + BYTE_OFS_W - 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cap_wr;
    logic [31:0]       cap_adr;
    logic [31:0]       cap_wdata;

    logic              sel_wr;
    logic [31:0]       sel_adr;
    logic [31:0]       sel_wdata;
    logic              sel_err;
    logic              enter_resp;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [31:0]       ram_rdata;

    // With zero wait states RESP is entered on the accepting edge itself,
    // so the live inputs stand in for the not-yet-loaded capture registers.
    always_comb begin
        sel_wr     = (state == IDLE) ? MemWrite  : cap_wr;
        sel_adr    = (state == IDLE) ? DataAdr   : cap_adr;
        sel_wdata  = (state == IDLE) ? WriteData : cap_wdata;
        sel_err    = (sel_adr[BYTE_OFS_W-1:0] != '0) || (sel_adr[31:IDX_HI+1] != '0);
        enter_resp = ((state == IDLE) && MemReq && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == CNT_W'(1)));
        ram_we     = enter_resp && sel_wr && !sel_err;
        ram_idx    = sel_adr[IDX_HI:BYTE_OFS_W];
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (sel_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_adr   <= '0;
            cap_wdata <= '0;
            ReadData  <= '0;
            MemReady  <= 1'b0;
            MemErr    <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemReq) begin
                        cap_wr    <= MemWrite;
                        cap_adr   <= DataAdr;
                        cap_wdata <= WriteData;
                        cnt       <= CNT_W'(LATENCY);
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    MemReady <= 1'b1;
                    MemErr   <= sel_err;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp && !sel_wr) begin
                ReadData <= sel_err ? '0 : ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench over five latency configurations
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [4:0]  req = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] rdata [5];
    logic        rdy [5];
    logic        err [5];

    int checks = 0;
    int failures = 0;

    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          os;

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        case (g)
            0: return 2;
            1: return 3;
            2: return 0;
            3: return 1;
            default: return 5;
        endcase
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (64),
            .LATENCY (lat_of(g))
        ) u_dut (
            .clk       (clk),
            .Reset     (Reset),
            .MemReq    (req[g]),
            .MemWrite  (MemWrite),
            .DataAdr   (DataAdr),
            .WriteData (WriteData),
            .ReadData  (rdata[g]),
            .MemReady  (rdy[g]),
            .MemErr    (err[g])
        );
    end

    task automatic txn(input int i, input logic wr, input logic [31:0] adr,
                       input logic [31:0] wd, input bit churn,
                       output int l, output logic [31:0] r, output logic e, output bit one);
        @(negedge clk);
        MemWrite = wr; DataAdr = adr; WriteData = wd; req[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[i] = 1'b0;
        l = 0;
        while (!rdy[i] && l < 40) begin
            if (churn) begin
                MemWrite = 1'($urandom); DataAdr = $urandom; WriteData = $urandom;
            end
            @(posedge clk); l++; @(negedge clk);
        end
        r = rdata[i]; e = err[i];
        @(posedge clk); @(negedge clk);
        one = !rdy[i];
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rdy[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_state dut%0d got rdy=%b err=%b rd=%h exp 0/0/0", i, rdy[i], err[i], rdata[i]);
            end
        end
        Reset = 1'b1;
    endtask

    task automatic test_write_read;
        txn(0, 1'b1, 32'h10, 32'h12345678, 1'b0, lat, rd, er, os);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
        checks++; if (os !== 1'b1) begin failures++; $display("FAIL rd_one_shot got=%b exp=1", os); end
        txn(0, 1'b1, 32'h14, 32'h00000001, 1'b0, lat, rd, er, os);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL store_keeps_rd got=%h exp=12345678", rd); end
    endtask

    task automatic test_reset_mid_wait;
        txn(1, 1'b1, 32'h08, 32'hCAFEF00D, 1'b0, lat, rd, er, os);
        checks++; if (lat !== 4) begin failures++; $display("FAIL l3_latency got=%0d exp=4", lat); end
        @(negedge clk);
        MemWrite = 1'b1; DataAdr = 32'h08; WriteData = 32'hDEADBEEF; req[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk); Reset = 1'b0;
        #1;
        checks++;
        if (rdy[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_state got rdy=%b err=%b rd=%h exp 0/0/0", rdy[1], err[1], rdata[1]);
        end
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        lat = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[1]) lat++;
        end
        checks++; if (lat !== 0) begin failures++; $display("FAIL aborted_pulses got=%0d exp=0", lat); end
        txn(1, 1'b0, 32'h08, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL aborted_store_mem got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_errors;
        txn(0, 1'b1, 32'h04, 32'h11112222, 1'b0, lat, rd, er, os);
        txn(0, 1'b1, 32'h06, 32'h99999999, 1'b0, lat, rd, er, os);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL misaligned_err got=%b exp=1", er); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL misaligned_latency got=%0d exp=3", lat); end
        txn(0, 1'b0, 32'h04, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (rd !== 32'h11112222 || er !== 1'b0) begin failures++; $display("FAIL misaligned_mem got rd=%h err=%b exp 11112222/0", rd, er); end
        txn(0, 1'b1, 32'h00, 32'h00000055, 1'b0, lat, rd, er, os);
        txn(0, 1'b1, 32'h100, 32'h000000EE, 1'b0, lat, rd, er, os);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_store_err got=%b exp=1", er); end
        txn(0, 1'b0, 32'h100, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL oor_load got rd=%h err=%b exp 0/1", rd, er); end
        txn(0, 1'b0, 32'h00, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (rd !== 32'h55 || er !== 1'b0) begin failures++; $display("FAIL oor_no_alias got rd=%h err=%b exp 55/0", rd, er); end
        txn(0, 1'b1, 32'hFC, 32'h00000077, 1'b0, lat, rd, er, os);
        txn(0, 1'b0, 32'hFC, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (rd !== 32'h77 || er !== 1'b0) begin failures++; $display("FAIL last_word got rd=%h err=%b exp 77/0", rd, er); end
    endtask

    task automatic test_churn;
        txn(0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, lat, rd, er, os);
        checks++; if (er !== 1'b0 || lat !== 3) begin failures++; $display("FAIL churn_store got err=%b lat=%0d exp 0/3", er, lat); end
        txn(0, 1'b0, 32'h20, 32'h0, 1'b1, lat, rd, er, os);
        checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin failures++; $display("FAIL churn_load got rd=%h err=%b exp a5a5a5a5/0", rd, er); end
    endtask

    task automatic test_back_to_back(input int i, input int l);
        int k;
        int k2;
        txn(i, 1'b1, 32'h30, 32'h0, 1'b0, lat, rd, er, os);
        checks++; if (lat !== l + 1) begin failures++; $display("FAIL sweep_latency dut%0d got=%0d exp=%0d", i, lat, l + 1); end
        checks++; if (os !== 1'b1) begin failures++; $display("FAIL sweep_one_shot dut%0d got=%b exp=1", i, os); end
        @(negedge clk);
        MemWrite = 1'b1; DataAdr = 32'h40; WriteData = 32'hC0DE0000 | 32'(i); req[i] = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!rdy[i] && k < 40) begin
            @(posedge clk); k++; @(negedge clk);
        end
        checks++; if (k !== l + 1) begin failures++; $display("FAIL held_first dut%0d got=%0d exp=%0d", i, k, l + 1); end
        MemWrite = 1'b0;
        k2 = 0;
        do begin
            @(posedge clk); k2++; @(negedge clk);
            if (k2 == 1) req[i] = 1'b0;
        end while (!rdy[i] && k2 < 40);
        checks++; if (k2 !== l + 2) begin failures++; $display("FAIL held_spacing dut%0d got=%0d exp=%0d", i, k2, l + 2); end
        checks++;
        if (rdata[i] !== (32'hC0DE0000 | 32'(i)) || err[i] !== 1'b0) begin
            failures++;
            $display("FAIL held_second_data dut%0d got rd=%h err=%b exp %h/0", i, rdata[i], err[i], 32'hC0DE0000 | 32'(i));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_mid_wait();
        test_errors();
        test_churn();
        test_back_to_back(2, 0);
        test_back_to_back(3, 1);
        test_back_to_back(4, 5);
        test_back_to_back(0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
